// File: rtl/hmem_ctrl.sv
// Multi-port burst memory controller: round-robin arbitration between requesters,
// fixed access latency, then a line-sized burst of read or write beats into local storage.
module hmem_ctrl #(
    parameter int NPORTS     = 2,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 8,
    parameter int DEPTH      = 4096,
    parameter int LAT        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req,
    input  logic [NPORTS-1:0]        we,
    input  logic [NPORTS*ADDR_W-1:0] addr,
    input  logic [NPORTS*DATA_W-1:0] wdata,
    output logic [NPORTS-1:0]        gnt,
    output logic [DATA_W-1:0]        rdata,
    output logic [NPORTS-1:0]        rvalid,
    output logic [NPORTS-1:0]        wready,
    output logic [NPORTS-1:0]        done
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int BW = $clog2(DATA_W / 8);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LAT + LINE_WORDS + 1) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [1:0]        state_r;
    logic [CW-1:0]     cnt_r;
    logic [PW-1:0]     port_r;
    logic [PW-1:0]     last_r;
    logic              we_r;
    logic [IW-1:0]     base_r;
    logic [IW-1:0]     widx_r;

    logic              pick_valid_s;
    logic [PW-1:0]     pick_s;
    logic [ADDR_W-1:0] pick_addr_s;
    logic [IW-1:0]     pick_base_s;
    logic [DATA_W-1:0] wdata_sel_s;
    logic [IW-1:0]     beat_idx_s;

    function automatic logic [NPORTS-1:0] onehot(input logic [PW-1:0] p);
        logic [NPORTS-1:0] v;
        v    = {NPORTS{1'b0}};
        v[p] = 1'b1;
        return v;
    endfunction

    // Round-robin search starting at the port after the last one granted
    always_comb begin
        pick_valid_s = 1'b0;
        pick_s       = last_r;
        for (int i = 1; i <= NPORTS; i++) begin
            if (!pick_valid_s && req[(int'(last_r) + i) % NPORTS]) begin
                pick_valid_s = 1'b1;
                pick_s       = PW'((int'(last_r) + i) % NPORTS);
            end else begin
                pick_valid_s = pick_valid_s;
            end
        end
    end

    // Line-aligned word index of the winner and per-beat operand selection
    always_comb begin
        pick_addr_s = addr[int'(pick_s) * ADDR_W +: ADDR_W];
        pick_base_s = IW'(pick_addr_s >> BW) & ~IW'(LINE_WORDS - 1);
        wdata_sel_s = wdata[int'(port_r) * DATA_W +: DATA_W];
        beat_idx_s  = base_r + IW'(cnt_r);
    end

    // Transaction FSM and registered outputs; outputs trail the state by one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CW{1'b0}};
            port_r  <= {PW{1'b0}};
            last_r  <= PW'(NPORTS - 1);
            we_r    <= 1'b0;
            base_r  <= {IW{1'b0}};
            widx_r  <= {IW{1'b0}};
            gnt     <= {NPORTS{1'b0}};
            rvalid  <= {NPORTS{1'b0}};
            wready  <= {NPORTS{1'b0}};
            done    <= {NPORTS{1'b0}};
            rdata   <= {DATA_W{1'b0}};
        end else begin
            rvalid <= {NPORTS{1'b0}};
            wready <= {NPORTS{1'b0}};
            done   <= {NPORTS{1'b0}};
            rdata  <= {DATA_W{1'b0}};
            // Grant drops on the edge after the done pulse; a new pick below overrides
            if (done != {NPORTS{1'b0}}) begin
                gnt <= {NPORTS{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (pick_valid_s) begin
                        port_r  <= pick_s;
                        last_r  <= pick_s;
                        we_r    <= we[pick_s];
                        base_r  <= pick_base_s;
                        gnt     <= onehot(pick_s);
                        cnt_r   <= {CW{1'b0}};
                        state_r <= (LAT == 0) ? ST_BURST : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r + CW'(1) == CW'(LAT)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_BURST;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_BURST: begin
                    if (we_r) begin
                        wready <= onehot(port_r);
                        widx_r <= beat_idx_s;
                    end else begin
                        rvalid <= onehot(port_r);
                        rdata  <= mem[beat_idx_s];
                    end
                    if (cnt_r + CW'(1) == CW'(LINE_WORDS)) begin
                        cnt_r   <= {CW{1'b0}};
                        state_r <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                ST_DONE: begin
                    done    <= onehot(port_r);
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Write beat lands on the edge closing its wready cycle; a reset in that cycle suppresses it
    always_ff @(posedge clk) begin
        if (!rst && (wready != {NPORTS{1'b0}})) begin
            mem[widx_r] <= wdata_sel_s;
        end
    end

endmodule

// File: tb/tb_hmem_ctrl.sv
// Scoreboard bench for hmem_ctrl: a LAT=4 instance and a LAT=0 instance, directed transactions,
// expected grant/beat/done events queued with their exact cycle and checked by a negedge monitor.
module tb_hmem_ctrl;

    typedef struct {
        int          inst;
        int          kind;   // 0 grant, 1 read beat, 2 write beat, 3 done
        int          port;
        int          cyc;
        logic [63:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [1:0]   req_i   [2];
    logic [1:0]   we_i    [2];
    logic [63:0]  addr_i  [2];
    logic [127:0] wdata_i [2];

    logic [1:0]  gnt_a, rvalid_a, wready_a, done_a;
    logic [1:0]  gnt_b, rvalid_b, wready_b, done_b;
    logic [63:0] rdata_a, rdata_b;
    logic [1:0]  gp_a = 2'b00;
    logic [1:0]  gp_b = 2'b00;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    exp_t q[$];
    logic [63:0] vec [8];

    hmem_ctrl #(.LAT(4)) u_a (
        .clk(clk), .rst(rst), .req(req_i[0]), .we(we_i[0]), .addr(addr_i[0]),
        .wdata(wdata_i[0]), .gnt(gnt_a), .rdata(rdata_a), .rvalid(rvalid_a),
        .wready(wready_a), .done(done_a)
    );

    hmem_ctrl #(.LAT(0)) u_b (
        .clk(clk), .rst(rst), .req(req_i[1]), .we(we_i[1]), .addr(addr_i[1]),
        .wdata(wdata_i[1]), .gnt(gnt_b), .rdata(rdata_b), .rvalid(rvalid_b),
        .wready(wready_b), .done(done_b)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic push(input int inst, input int kind, input int port, input int c, input logic [63:0] d);
        exp_t e;
        e.inst = inst; e.kind = kind; e.port = port; e.cyc = c; e.data = d;
        q.push_back(e);
    endtask

    task automatic ev(input int inst, input int kind, input logic [1:0] v, input logic [63:0] d);
        exp_t e;
        int   port;
        bit   ok;
        port = v[1] ? 1 : 0;
        n_checks++;
        if (q.size() == 0) begin
            $display("FAIL event: unexpected inst %0d kind %0d port %0d data 0x%0h at cycle %0d",
                     inst, kind, port, d, cyc);
        end else begin
            e  = q.pop_front();
            ok = (e.inst == inst) && (e.kind == kind) && (e.port == port) && (e.cyc == cyc) &&
                 ((kind != 1) || (e.data == d));
            if (ok) n_pass++;
            else $display("FAIL event: got inst %0d kind %0d port %0d cyc %0d data 0x%0h, expected inst %0d kind %0d port %0d cyc %0d data 0x%0h",
                          inst, kind, port, cyc, d, e.inst, e.kind, e.port, e.cyc, e.data);
        end
    endtask

    task automatic observe(input int inst, input logic [1:0] g, input logic [1:0] gp, input logic [1:0] rv,
                           input logic [1:0] wr, input logic [1:0] dn, input logic [63:0] rd);
        bit inv;
        inv = $onehot0(g) && $onehot0(rv) && $onehot0(wr) && $onehot0(dn) &&
              (((rv | wr | dn) & ~g) == 2'b00) && ((rv != 2'b00) || (rd == 64'd0));
        chk(inv, "invariant", {48'd0, 2'b00, g, 2'b00, rv, 2'b00, wr, 2'b00, dn}, 64'd0);
        if ((g != gp) && (g != 2'b00)) ev(inst, 0, g, 64'd0);
        if (rv != 2'b00) ev(inst, 1, rv, rd);
        if (wr != 2'b00) ev(inst, 2, wr, 64'd0);
        if (dn != 2'b00) ev(inst, 3, dn, 64'd0);
    endtask

    // Monitor: sample both instances away from the active edge
    always @(negedge clk) begin
        observe(0, gnt_a, gp_a, rvalid_a, wready_a, done_a, rdata_a);
        observe(1, gnt_b, gp_b, rvalid_b, wready_b, done_b, rdata_b);
        gp_a <= gnt_a;
        gp_b <= gnt_b;
    end

    task automatic chk_zero_a(input string name);
        chk(((gnt_a | rvalid_a | wready_a | done_a) == 2'b00) && (rdata_a == 64'd0), name,
            {56'd0, gnt_a, rvalid_a, wready_a, done_a} | rdata_a, 64'd0);
    endtask

    // One transaction; abort_beat >= 0 pulses reset during that write beat
    task automatic do_txn(input int inst, input int p, input logic w, input logic [31:0] a, input int abort_beat);
        int   t, k, lat;
        bit   finished;
        logic wr_s, dn_s;
        lat = (inst == 0) ? 4 : 0;
        @(posedge clk); #1;
        t = cyc;
        req_i[inst][p]              = 1'b1;
        we_i[inst][p]               = w;
        addr_i[inst][p*32 +: 32]    = a;
        wdata_i[inst][p*64 +: 64]   = vec[0];
        push(inst, 0, p, t + 1, 64'd0);
        for (int b = 0; b < 8; b++) begin
            if (abort_beat < 0 || b <= abort_beat)
                push(inst, w ? 2 : 1, p, t + lat + 2 + b, w ? 64'd0 : vec[b]);
        end
        if (abort_beat < 0) push(inst, 3, p, t + lat + 10, 64'd0);
        @(posedge clk); #1;
        req_i[inst][p]           = 1'b0;
        we_i[inst][p]            = ~w;
        addr_i[inst][p*32 +: 32] = 32'hFFFF_FFF0;
        k = 0;
        finished = 1'b0;
        for (int c = 0; c < 40 && !finished; c++) begin
            @(negedge clk);
            wr_s = (inst == 0) ? wready_a[p] : wready_b[p];
            dn_s = (inst == 0) ? done_a[p] : done_b[p];
            if (abort_beat >= 0 && wr_s && k == abort_beat) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk_zero_a("abort_outputs_zero");
                finished = 1'b1;
            end else if (dn_s) begin
                finished = 1'b1;
            end else begin
                @(posedge clk); #1;
                if (wr_s) begin
                    k++;
                    if (k < 8) wdata_i[inst][p*64 +: 64] = vec[k];
                end
            end
        end
        chk(finished, "txn_end", {63'd0, finished}, 64'd1);
    endtask

    initial begin
        int t;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_i[i] = 2'b00; we_i[i] = 2'b00; addr_i[i] = 64'd0; wdata_i[i] = 128'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_zero_a("reset_outputs");

        // Preload 0x40..0x47 at line 8..15, then single read of 0x40
        for (int b = 0; b < 8; b++) vec[b] = 64'h40 + 64'(b);
        do_txn(0, 1, 1'b1, 32'h40, -1);
        do_txn(0, 0, 1'b0, 32'h40, -1);

        // Write via port 1, read back through an unaligned address in the same line
        for (int b = 0; b < 8; b++) vec[b] = 64'hA0 + 64'(b);
        do_txn(0, 1, 1'b1, 32'h100, -1);
        do_txn(0, 0, 1'b0, 32'h104, -1);

        // Address beyond storage wraps to index 0
        for (int b = 0; b < 8; b++) vec[b] = 64'h10 + 64'(b);
        do_txn(0, 1, 1'b1, 32'h0, -1);
        do_txn(0, 0, 1'b0, 32'h8000, -1);

        // Reset during beat 3 of a write: beats 0..2 land, 3..7 keep old contents
        for (int b = 0; b < 8; b++) vec[b] = 64'hC0 + 64'(b);
        do_txn(0, 1, 1'b1, 32'h200, -1);
        for (int b = 0; b < 8; b++) vec[b] = 64'hB0 + 64'(b);
        do_txn(0, 1, 1'b1, 32'h200, 3);
        for (int b = 0; b < 8; b++) vec[b] = (b < 3) ? 64'hB0 + 64'(b) : 64'hC0 + 64'(b);
        do_txn(0, 0, 1'b0, 32'h200, -1);

        // Contention from reset: both ports request continuously, grants alternate 0,1,0,1
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        t = cyc;
        we_i[0]   = 2'b00;
        addr_i[0] = {32'h100, 32'h40};
        req_i[0]  = 2'b11;
        for (int j = 0; j < 4; j++) begin
            push(0, 0, j % 2, t + 1 + 14 * j, 64'd0);
            for (int b = 0; b < 8; b++)
                push(0, 1, j % 2, t + 6 + 14 * j + b, ((j % 2) == 0) ? 64'h40 + 64'(b) : 64'hA0 + 64'(b));
            push(0, 3, j % 2, t + 14 + 14 * j, 64'd0);
        end
        while (cyc < t + 44) begin @(posedge clk); #1; end
        req_i[0] = 2'b00;
        while (cyc < t + 62) begin @(posedge clk); #1; end

        // Zero-latency build: first beat one cycle after grant
        for (int b = 0; b < 8; b++) vec[b] = 64'h50 + 64'(b);
        do_txn(1, 1, 1'b1, 32'h80, -1);
        do_txn(1, 0, 1'b0, 32'h80, -1);

        repeat (5) @(posedge clk);
        #1;
        chk(q.size() == 0, "queue_drained", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hmem_ctrl.md
HMEM_CTRL -- requirements
Module: hmem_ctrl

Interface
REQ-001 SHALL have parameter NPORTS, default 2, number of requester ports (port 0 = instruction cache, port 1 = data cache).
REQ-002 SHALL have parameter DATA_W, default 64, beat width in bits, power of two and at least 8.
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter LINE_WORDS, default 8, beats per cache-line burst, power of two.
REQ-005 SHALL have parameter DEPTH, default 4096, storage size in DATA_W words, power of two.
REQ-006 SHALL have parameter LAT, default 4, idle cycles between grant and first beat, 0 allowed.
REQ-007 SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-009 SHALL have port req, input, NPORTS bits, per-port transaction request.
REQ-010 SHALL have port we, input, NPORTS bits, per-port write (1) or read (0).
REQ-011 SHALL have port addr, input, NPORTS*ADDR_W bits, packed per-port byte address, port i at [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port wdata, input, NPORTS*DATA_W bits, packed per-port write beat.
REQ-013 SHALL have port gnt, output, NPORTS bits, one-hot grant, held for the whole transaction.
REQ-014 SHALL have port rdata, output, DATA_W bits, shared read beat.
REQ-015 SHALL have port rvalid, output, NPORTS bits, read beat valid for the granted port.
REQ-016 SHALL have port wready, output, NPORTS bits, write beat consumed this cycle for the granted port.
REQ-017 SHALL have port done, output, NPORTS bits, one-cycle transaction-complete pulse.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, BURST, DONE.
REQ-019 In IDLE with any req bit high, SHALL pick one port round-robin, starting the search at the port after the last granted one, and latch its we and line-aligned addr.
REQ-020 SHALL assert gnt for the chosen port in the cycle after the IDLE decision and hold it until the cycle of done inclusive.
REQ-021 SHALL move IDLE->WAIT on grant, stay in WAIT for exactly LAT cycles, then go to BURST; with LAT=0 it SHALL go IDLE->BURST directly.
REQ-022 In BURST, SHALL perform LINE_WORDS beats on consecutive cycles with no bubbles; beat k accesses word index (line_base + k) mod DEPTH.
REQ-023 Word index SHALL be addr / (DATA_W/8); the low log2(LINE_WORDS) index bits are forced to 0, and the upper bits beyond DEPTH wrap modulo DEPTH.
REQ-024 On a read beat, SHALL drive rdata with the stored word and assert rvalid[g] in that cycle only.
REQ-025 On a write beat, SHALL assert wready[g] and write wdata[g] at that edge; the requester presents beat k+1 in the cycle after wready.
REQ-026 After the last beat, SHALL enter DONE for one cycle, pulse done[g], deassert gnt on the next edge, and return to IDLE.
REQ-027 First-grant latency from req (idle controller) SHALL be 1 cycle; the first beat is LAT+1 cycles after gnt rises; done follows the last beat by 1 cycle.
REQ-028 Dropping req mid-transaction SHALL NOT abort it; changes to addr or we after the grant SHALL be ignored.
REQ-029 A req held through done SHALL be eligible for arbitration in the following IDLE cycle, subject to round-robin order.
REQ-030 rvalid, wready and done SHALL never be high for a non-granted port, and at most one bit of each SHALL be high.
REQ-031 rdata SHALL be 0 when no rvalid bit is high.

Reset
REQ-032 While rst is high: state = IDLE; gnt, rvalid, wready, done and rdata = 0; round-robin pointer set so port 0 has first priority.
REQ-033 Reset asserted mid-transaction SHALL abort it with no further beats or done; words already written stay written.
REQ-034 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-035 Single read: port 0 reads addr 0x40 with LAT=4 and words 0x40..0x47 preloaded at index 8..15 -> gnt[0] at t+1, 8 rvalid beats at t+6..t+13 in index order, done[0] at t+14.
REQ-036 Write then read: port 1 writes 0xA0..0xA7 to addr 0x100, then port 0 reads addr 0x104 -> reads return 0xA0..0xA7 (low bits ignored).
REQ-037 Contention: both ports request continuously from reset -> grants alternate 0,1,0,1, with no overlap of gnt.
REQ-038 Wrap: read at byte addr DEPTH*8 (DATA_W=64) -> returns words from index 0..7.
REQ-039 Reset on beat 3 of a port 1 write -> beats 0..2 stored, beats 3..7 unchanged, no done, all outputs 0 the next cycle.
REQ-040 LAT=0 build: single read -> first rvalid 1 cycle after gnt.
